// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: controller
// states and the address-field layout derived from LINES and WORDS.
package icache_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_e;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned WORD_LSB = 2;

  function automatic int unsigned index_lsb(input int unsigned words);
    return WORD_LSB + $clog2(words);
  endfunction

  function automatic int unsigned tag_lsb(input int unsigned lines, input int unsigned words);
    return index_lsb(words) + $clog2(lines);
  endfunction

  function automatic int unsigned tag_width(input int unsigned lines, input int unsigned words);
    return ADDR_W - tag_lsb(lines, words);
  endfunction

endpackage

// File: rtl/icache_line_ram.sv
// Cache data store: one synchronous write port, one combinational read port.
module icache_line_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache with zero-latency hits and a word-by-word
// line refill from backing memory; supports invalidate-all (fence.i).
module icache
  import icache_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_i_addr,
  input  logic        cpu_i_rstrb,
  output logic [31:0] cpu_i_rdata,
  output logic        cpu_i_rbusy,
  output logic [31:0] mem_addr,
  output logic        mem_rstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rbusy,
  input  logic        inv
);

  localparam int unsigned WB      = $clog2(WORDS);
  localparam int unsigned IB      = $clog2(LINES);
  localparam int unsigned IDX_LSB = index_lsb(WORDS);
  localparam int unsigned TAG_LSB = tag_lsb(LINES, WORDS);
  localparam int unsigned TAG_W   = tag_width(LINES, WORDS);
  localparam int unsigned LINE_W  = ADDR_W - IDX_LSB;

  state_e            state_q;
  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q [LINES];
  logic [LINE_W-1:0] line_q;
  logic [WB-1:0]     cnt_q;
  logic              abort_q;
  logic [31:0]       mem_addr_q;
  logic              mem_rstrb_q;

  logic [TAG_W-1:0]  cpu_tag;
  logic [IB-1:0]     cpu_idx;
  logic [WB-1:0]     cpu_word;
  logic [IB-1:0]     fill_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic              hit;
  logic              miss_start;
  logic              accept;
  logic              last;
  logic              unused_addr_bits;

  assign cpu_tag  = cpu_i_addr[ADDR_W-1:TAG_LSB];
  assign cpu_idx  = cpu_i_addr[TAG_LSB-1:IDX_LSB];
  assign cpu_word = cpu_i_addr[IDX_LSB-1:WORD_LSB];
  assign unused_addr_bits = ^cpu_i_addr[WORD_LSB-1:0];

  // line_q holds {tag, index} of the line being refilled
  assign fill_idx = line_q[IB-1:0];
  assign fill_tag = line_q[LINE_W-1:IB];

  assign hit        = (state_q == IDLE) && valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
  assign miss_start = (state_q == IDLE) && cpu_i_rstrb && !hit;
  assign accept     = (state_q == REFILL) && !mem_rbusy;
  assign last       = accept && (&cnt_q);

  assign cpu_i_rbusy = cpu_i_rstrb && !hit;
  assign mem_addr    = mem_addr_q;
  assign mem_rstrb   = mem_rstrb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      line_q      <= '0;
      cnt_q       <= '0;
      abort_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_rstrb_q <= 1'b0;
    end else begin
      if (inv) begin
        valid_q <= '0;
      end
      case (state_q)
        IDLE: begin
          if (miss_start) begin
            state_q     <= REFILL;
            line_q      <= cpu_i_addr[ADDR_W-1:IDX_LSB];
            cnt_q       <= '0;
            mem_rstrb_q <= 1'b1;
            mem_addr_q  <= {cpu_i_addr[ADDR_W-1:IDX_LSB], {IDX_LSB{1'b0}}};
          end
        end
        REFILL: begin
          if (inv) begin
            abort_q <= 1'b1;
          end
          if (accept) begin
            cnt_q <= cnt_q + WB'(1);
            if (last) begin
              // An invalidate seen at any point of the refill, including
              // this final edge, leaves the line invalid.
              state_q     <= IDLE;
              mem_rstrb_q <= 1'b0;
              abort_q     <= 1'b0;
              if (!abort_q && !inv) begin
                valid_q[fill_idx] <= 1'b1;
              end
            end else begin
              mem_addr_q <= {line_q, cnt_q + WB'(1), 2'b00};
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (last) begin
      tag_q[fill_idx] <= fill_tag;
    end
  end

  icache_line_ram #(
    .DEPTH(LINES * WORDS),
    .AW   (IB + WB)
  ) u_data (
    .clk    (clk),
    .we_i   (accept),
    .waddr_i({fill_idx, cnt_q}),
    .wdata_i(mem_rdata),
    .raddr_i({cpu_idx, cpu_word}),
    .rdata_o(cpu_i_rdata)
  );

endmodule
